seq_calc: RTL and testbench
===========================

SEQ_CALC -- requirements
Module: seq_calc

Interface
REQ-001 Parameter: W, default 16, operand/accumulator width in bits (two's complement).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  in  1  command present.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-006 cmd_load  in  1  1 = load operand into ACC; 0 = arithmetic op.
REQ-007 cmd_op  in  3  opcode, ignored when cmd_load=1.
REQ-008 cmd_x  in  W  command operand X.
REQ-009 res_valid  out  1  result present.
REQ-010 res_ready  in  1  result consumed when res_valid & res_ready.
REQ-011 res_r  out  W  result value; equals ACC after the command.
REQ-012 res_ovf  out  1  overflow of this result.
REQ-013 acc  out  W  current accumulator contents.
REQ-014 sticky_ovf  out  1  OR of res_ovf since last load (macro-gated, see Configuration).

Function
REQ-015 Opcodes, A=ACC, B=X: 000 A+B; 001 A-B; 01x |B|; 100 B+A; 101 B-A; 11x |A|.
REQ-016 Add/sub wrap modulo 2^W; ovf = signed overflow (operands same sign for add, opposite for sub, result sign differs from first operand).
REQ-017 abs of non-negative value returns it unchanged with ovf=0; abs of negative returns the two's complement; abs of -2^(W-1) returns -2^(W-1) with ovf=1.
REQ-018 Load: ACC <= X, res_r = X, res_ovf = 0.
REQ-019 FSM states: IDLE, EXEC, RESP.
REQ-020 IDLE: cmd_ready=1; on accept, latch cmd_load/cmd_op/cmd_x, go to EXEC.
REQ-021 EXEC: cmd_ready=0, res_valid=0; compute, write ACC, res_r, res_ovf; go to RESP.
REQ-022 RESP: res_valid=1, res_r/res_ovf held stable; cmd_ready = res_ready.
REQ-023 RESP with res_ready=1: next state is EXEC if cmd_valid=1 (command latched in the same cycle), else IDLE.
REQ-024 RESP with res_ready=0: remain in RESP; commands not accepted.
REQ-025 Latency: result valid exactly 2 cycles after the accept edge; back-to-back throughput is one command per 2 cycles.
REQ-026 ACC is updated only in EXEC; the ACC value is never partially updated.
REQ-027 cmd_op/cmd_x changes while not accepted have no effect.

Reset
REQ-028 Reset applies asynchronously and forces: state IDLE, ACC=0, res_r=0, res_ovf=0, res_valid=0, sticky_ovf=0; cmd_ready=1 after release.
REQ-029 Reset during EXEC or RESP discards the in-flight command and result; no handshake completes.

Configuration
REQ-030 Macro SEQ_CALC_STICKY_OVF_EN defined: sticky_ovf is set in EXEC when res_ovf=1, cleared by a load command, and held otherwise.
REQ-031 Macro not defined: sticky_ovf is tied to 0 and no sticky register exists; all other behaviour is identical.

Structure
REQ-032 Shared package calc_pkg holds: opcode constants (OP_ADD_AB, OP_SUB_AB, OP_ABS_B, OP_ADD_BA, OP_SUB_BA, OP_ABS_A); FSM state enum type.
REQ-033 Sub-module calc_alu: purely combinational, inputs op/A/B, outputs R/ovf per REQ-015..017, parameterized by W; instantiated once in EXEC datapath.

Verification
REQ-034 Scenario: load 0x7FFF, then op 000 X=1 -> res_r=0x8000, res_ovf=1, sticky_ovf=1 (macro on) / 0 (macro off).
REQ-035 Scenario: load 5, op 101 X=3 -> res_r=0xFFFE, ovf=0; then op 11x -> res_r=0x0002, ovf=0.
REQ-036 Scenario: load 0x8000, op 11x -> res_r=0x8000, res_ovf=1; next load 0 -> sticky_ovf=0.
REQ-037 Scenario: hold res_ready=0 for 5 cycles in RESP with cmd_valid=1 -> cmd_ready=0 and res_r stable throughout; raise res_ready -> command accepted that cycle, next result 2 cycles later.
REQ-038 Scenario: assert rst mid-EXEC -> outputs at reset values immediately, acc=0, no res_valid pulse after release.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared opcode constants and FSM state type for the sequential calculator.
package calc_pkg;

    localparam logic [2:0] OP_ADD_AB = 3'b000;
    localparam logic [2:0] OP_SUB_AB = 3'b001;
    localparam logic [2:0] OP_ABS_B  = 3'b010;
    localparam logic [2:0] OP_ADD_BA = 3'b100;
    localparam logic [2:0] OP_SUB_BA = 3'b101;
    localparam logic [2:0] OP_ABS_A  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational ALU: add/sub in either operand order, or abs of A/B, with signed overflow.
// Zero latency; no flow control.
module calc_alu
    import calc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [2:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] r_o,
    output logic         ovf_o
);

    logic [W-1:0] first;
    logic [W-1:0] second;
    logic [W-1:0] sum;
    logic [W-1:0] dif;
    logic [W-1:0] absv;

    always_comb begin
        // op[2] swaps operand order; for the abs group it selects A instead of B.
        first  = op_i[2] ? b_i : a_i;
        second = op_i[2] ? a_i : b_i;
        absv   = op_i[2] ? a_i : b_i;
        sum    = first + second;
        dif    = first - second;
        r_o    = '0;
        ovf_o  = 1'b0;
        case (op_i)
            OP_ADD_AB, OP_ADD_BA: begin
                r_o   = sum;
                ovf_o = (first[W-1] == second[W-1]) && (sum[W-1] != first[W-1]);
            end
            OP_SUB_AB, OP_SUB_BA: begin
                r_o   = dif;
                ovf_o = (first[W-1] != second[W-1]) && (dif[W-1] != first[W-1]);
            end
            default: begin
                r_o   = absv[W-1] ? -absv : absv;
                // Only the most negative value stays negative after negation.
                ovf_o = absv[W-1] && r_o[W-1];
            end
        endcase
    end

endmodule

// File: rtl/seq_calc.sv
// Accumulator calculator: IDLE -> EXEC -> RESP, result valid 2 cycles after accept, 1 cmd / 2 cycles.
// Backpressure: res_ready low holds RESP and blocks commands. Define SEQ_CALC_STICKY_OVF_EN for sticky_ovf.
module seq_calc
    import calc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_load,
    input  logic [2:0]   cmd_op,
    input  logic [W-1:0] cmd_x,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_r,
    output logic         res_ovf,
    output logic [W-1:0] acc,
    output logic         sticky_ovf
);

    state_t       state_q, state_d;
    logic         ld_q;
    logic [2:0]   op_q;
    logic [W-1:0] x_q;
    logic [W-1:0] acc_q;
    logic [W-1:0] res_r_q;
    logic         res_ovf_q;
    logic         accept;
    logic [W-1:0] alu_r;
    logic         alu_ovf;
    logic [W-1:0] exec_r;
    logic         exec_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (res_ready) state_d = cmd_valid ? ST_EXEC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && res_ready);
        res_valid = (state_q == ST_RESP);
    end

    assign accept = cmd_valid & cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_q <= 1'b0;
            op_q <= '0;
            x_q  <= '0;
        end else if (accept) begin
            ld_q <= cmd_load;
            op_q <= cmd_op;
            x_q  <= cmd_x;
        end
    end

    calc_alu #(.W(W)) u_alu (
        .op_i  (op_q),
        .a_i   (acc_q),
        .b_i   (x_q),
        .r_o   (alu_r),
        .ovf_o (alu_ovf)
    );

    assign exec_r   = ld_q ? x_q : alu_r;
    assign exec_ovf = ld_q ? 1'b0 : alu_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            res_r_q   <= '0;
            res_ovf_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            acc_q     <= exec_r;
            res_r_q   <= exec_r;
            res_ovf_q <= exec_ovf;
        end
    end

`ifdef SEQ_CALC_STICKY_OVF_EN
    logic sticky_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            if (ld_q)          sticky_q <= 1'b0;
            else if (exec_ovf) sticky_q <= 1'b1;
        end
    end

    assign sticky_ovf = sticky_q;
`else
    assign sticky_ovf = 1'b0;
`endif

    assign acc     = acc_q;
    assign res_r   = res_r_q;
    assign res_ovf = res_ovf_q;

endmodule

// File: tb/tb_seq_calc.sv
// Directed self-checking bench for seq_calc (W=16) with hand-computed expected results.
module tb_seq_calc;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_load;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_x;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_r;
    logic        res_ovf;
    logic [15:0] acc;
    logic        sticky_ovf;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SEQ_CALC_STICKY_OVF_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    seq_calc #(.W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_load   (cmd_load),
        .cmd_op     (cmd_op),
        .cmd_x      (cmd_x),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_r      (res_r),
        .res_ovf    (res_ovf),
        .acc        (acc),
        .sticky_ovf (sticky_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command from IDLE with res_ready=1, check the result, return in IDLE.
    task automatic send(input string tag, input logic ld, input logic [2:0] op,
                        input logic [15:0] x, input logic [15:0] er, input logic eo,
                        input logic es);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_x     = x;
        check({tag, ".rdy"}, {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_x     = 16'hDEAD;
        check({tag, ".exec_vld"}, {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        check({tag, ".vld"}, {31'd0, res_valid}, 32'd1);
        check({tag, ".r"}, {16'd0, res_r}, {16'd0, er});
        check({tag, ".ovf"}, {31'd0, res_ovf}, {31'd0, eo});
        check({tag, ".acc"}, {16'd0, acc}, {16'd0, er});
        check({tag, ".sticky"}, {31'd0, sticky_ovf}, {31'd0, es});
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = 3'b000;
        cmd_x     = 16'h0000;
        res_ready = 1'b1;
        #2;
        check("rst.acc", {16'd0, acc}, 32'd0);
        check("rst.res_r", {16'd0, res_r}, 32'd0);
        check("rst.res_vld", {31'd0, res_valid}, 32'd0);
        check("rst.res_ovf", {31'd0, res_ovf}, 32'd0);
        check("rst.sticky", {31'd0, sticky_ovf}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.cmd_rdy", {31'd0, cmd_ready}, 32'd1);

        // Overflow on add, sticky follows when enabled.
        send("ld7fff", 1'b1, 3'b000, 16'h7FFF, 16'h7FFF, 1'b0, 1'b0);
        send("add_ab", 1'b0, 3'b000, 16'h0001, 16'h8000, 1'b1, STK);
        send("ld5",    1'b1, 3'b111, 16'h0005, 16'h0005, 1'b0, 1'b0);
        send("sub_ba", 1'b0, 3'b101, 16'h0003, 16'hFFFE, 1'b0, 1'b0);
        send("abs_a",  1'b0, 3'b110, 16'h1234, 16'h0002, 1'b0, 1'b0);
        send("sub_ab", 1'b0, 3'b001, 16'h0005, 16'hFFFD, 1'b0, 1'b0);
        send("abs_b",  1'b0, 3'b011, 16'h8001, 16'h7FFF, 1'b0, 1'b0);
        send("add_ba", 1'b0, 3'b100, 16'h0001, 16'h8000, 1'b1, STK);
        send("sub_ovf",1'b0, 3'b001, 16'h0001, 16'h7FFF, 1'b1, STK);
        send("ld8000", 1'b1, 3'b000, 16'h8000, 16'h8000, 1'b0, 1'b0);
        send("abs_min",1'b0, 3'b111, 16'h0000, 16'h8000, 1'b1, STK);
        send("ld0",    1'b1, 3'b000, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Backpressure: result held in RESP while a second command waits.
        res_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_op    = 3'b000;
        cmd_x     = 16'h0010;
        @(negedge clk);
        cmd_load  = 1'b0;
        cmd_op    = 3'b000;
        cmd_x     = 16'h0100;
        check("bp.exec_rdy", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp.vld", {31'd0, res_valid}, 32'd1);
            check("bp.rdy", {31'd0, cmd_ready}, 32'd0);
            check("bp.r", {16'd0, res_r}, 32'h0010);
            cmd_x = 16'h0100 + 16'(i);
            cmd_op = 3'(i);
            @(negedge clk);
        end
        cmd_op    = 3'b000;
        cmd_x     = 16'h0001;
        res_ready = 1'b1;
        #1;
        check("bp.release_rdy", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp.exec_vld", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        check("bp.next_vld", {31'd0, res_valid}, 32'd1);
        check("bp.next_r", {16'd0, res_r}, 32'h0011);
        check("bp.next_ovf", {31'd0, res_ovf}, 32'd0);
        @(negedge clk);

        // Reset while the command is in EXEC.
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = 3'b000;
        cmd_x     = 16'h0002;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mrst.acc", {16'd0, acc}, 32'd0);
        check("mrst.res_r", {16'd0, res_r}, 32'd0);
        check("mrst.vld", {31'd0, res_valid}, 32'd0);
        check("mrst.sticky", {31'd0, sticky_ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mrst.post_vld", {31'd0, res_valid}, 32'd0);
            check("mrst.post_acc", {16'd0, acc}, 32'd0);
            check("mrst.post_rdy", {31'd0, cmd_ready}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
